// File: rtl/pio_pkg.sv
// Shared definitions for the PIO interrupt servicer: the slave register map
// and the servicing state machine encoding.
package pio_pkg;

    // PIO s1 register addresses used by the servicer
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Servicing sequence; INIT_MASK is entered only from reset
    typedef enum logic [2:0] {
        INIT_MASK = 3'd0,
        IDLE      = 3'd1,
        RD_EDGE   = 3'd2,
        WT_EDGE   = 3'd3,
        CLR_EDGE  = 3'd4,
        RD_LEVEL  = 3'd5,
        WT_LEVEL  = 3'd6
    } pio_state_e;

endpackage

// File: rtl/pio_event_slot.sv
// Single-entry event holding register. A committed event either loads the
// slot (empty, or being accepted in the same cycle) or merges into the
// pending one, OR-ing the edges, replacing the levels and raising overflow.
module pio_event_slot #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] edges_i,
    input  logic [WIDTH-1:0] level_i,
    input  logic             ev_ready_i,
    input  logic             overflow_clr_i,
    output logic             ev_valid_o,
    output logic [WIDTH-1:0] ev_edges_o,
    output logic [WIDTH-1:0] ev_level_o,
    output logic             overflow_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             real_commit;

    // Handshake: an event transfers on every cycle where ev_valid and ev_ready
    // are both high; ev_valid never drops without a transfer, and the payload
    // is stable while ev_valid is high and ev_ready is low, except when a new
    // event merges into it.
    assign accept      = valid_q & ev_ready_i;
    assign real_commit = commit_i & (edges_i != '0);

    // Load, merge or drain the slot; a same-cycle overflow set beats the clear
    always_comb begin
        valid_d = valid_q;
        edges_d = edges_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (overflow_clr_i) begin
            ovf_d = 1'b0;
        end
        if (real_commit) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                edges_d = edges_i;
                level_d = level_i;
            end else begin
                edges_d = edges_q | edges_i;
                level_d = level_i;
                ovf_d   = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            edges_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            edges_q <= edges_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ev_valid_o = valid_q;
    assign ev_edges_o = edges_q;
    assign ev_level_o = level_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pio_irq_servicer.sv
// Avalon-MM master that programs an edge-capturing PIO's irq mask after reset,
// then on each PIO interrupt reads and clears the edge capture, reads the pin
// levels and hands the result to downstream logic as a valid/ready event.
// Bus outputs are registers loaded with the access belonging to the next state.
module pio_irq_servicer
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH     = 3,
    parameter logic [WIDTH-1:0] MASK_INIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             irq,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_edges,
    output logic [WIDTH-1:0] ev_level,
    output logic             overflow,
    input  logic             overflow_clr,
    output pio_state_e       dbg_state_o
);

    pio_state_e       state_q, state_d;
    logic             init_done_q, init_done_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [1:0]       addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             wr_n_q, wr_n_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             unused_readdata;

    // Only the low WIDTH bits of read data carry PIO state
    assign unused_readdata = ^m_readdata;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r            = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Next state and the bus access to present during that state
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        edge_d      = edge_q;
        addr_d      = PIO_ADDR_DATA;
        cs_d        = 1'b0;
        wr_n_d      = 1'b1;
        wdata_d     = '0;
        case (state_q)
            INIT_MASK: begin
                // First cycle after reset: stay one more cycle to show the mask write
                if (!init_done_q) begin
                    init_done_d = 1'b1;
                    cs_d        = 1'b1;
                    wr_n_d      = 1'b0;
                    addr_d      = PIO_ADDR_MASK;
                    wdata_d     = zext(MASK_INIT);
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (irq) begin
                    state_d = RD_EDGE;
                    cs_d    = 1'b1;
                    addr_d  = PIO_ADDR_EDGE;
                end
            end
            RD_EDGE: begin
                state_d = WT_EDGE;
            end
            WT_EDGE: begin
                // Read data is valid now; write the same value back to clear capture
                edge_d  = m_readdata[WIDTH-1:0];
                state_d = CLR_EDGE;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = PIO_ADDR_EDGE;
                wdata_d = zext(m_readdata[WIDTH-1:0]);
            end
            CLR_EDGE: begin
                state_d = RD_LEVEL;
                cs_d    = 1'b1;
                addr_d  = PIO_ADDR_DATA;
            end
            RD_LEVEL: begin
                state_d = WT_LEVEL;
            end
            WT_LEVEL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bus registers; reset aborts any service in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT_MASK;
            init_done_q <= 1'b0;
            edge_q      <= '0;
            addr_q      <= PIO_ADDR_DATA;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            edge_q      <= edge_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            wdata_q     <= wdata_d;
        end
    end

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wr_n_q;
    assign m_writedata  = wdata_q;
    assign dbg_state_o  = state_q;

    pio_event_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk            (clk),
        .reset_n        (reset_n),
        .commit_i       (state_q == WT_LEVEL),
        .edges_i        (edge_q),
        .level_i        (m_readdata[WIDTH-1:0]),
        .ev_ready_i     (ev_ready),
        .overflow_clr_i (overflow_clr),
        .ev_valid_o     (ev_valid),
        .ev_edges_o     (ev_edges),
        .ev_level_o     (ev_level),
        .overflow_o     (overflow)
    );

endmodule
